// File: rtl/aes_key_sched.sv
// Word-serial AES-128/192/256 key schedule: one expanded word per cycle, round keys streamed over valid/ready.
// Optional round-key store with a combinational read port is enabled by defining AES_KEY_SCHED_STORE_EN.
module aes_key_sched #(
    parameter int NK_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*NK_MAX-1:0]  key,
    input  logic                  abort,
    input  logic                  rk_ready,
    output logic                  rk_valid,
    output logic [127:0]          rk_data,
    output logic [3:0]            rk_idx,
    output logic                  rk_last,
    output logic                  busy,
    output logic                  done,
`ifdef AES_KEY_SCHED_STORE_EN
    input  logic [3:0]            rd_idx,
    output logic [127:0]          rd_key,
`endif
    output logic                  err
);

    localparam int         KW      = 32 * NK_MAX;
    localparam int         IW      = (NK_MAX > 1) ? $clog2(NK_MAX) : 1;
    localparam logic [3:0] NK_MAX4 = 4'(NK_MAX);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [3:0]  nk, nr, dec_nk, dec_nr;
    logic        start_legal;
    logic [5:0]  wi;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic        prod_done;
    logic [31:0] win [NK_MAX];
    logic [31:0] rk_buf [3];
    logic [31:0] key_word [NK_MAX];
    logic [IW-1:0] load_base, old_sel;
    logic [31:0] prev_word, old_word, sub_in, sub_out, new_word;
    logic        prefill, last_word, phase_wrap, xfer, produce;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int n = 0; n < 7; n++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    for (genvar j = 0; j < NK_MAX; j++) begin : g_key_word
        assign key_word[j] = key[KW-1-32*j -: 32];
    end

    always_comb begin
        dec_nk = 4'd0;
        dec_nr = 4'd0;
        case (key_len)
            2'b00:   begin dec_nk = 4'd4; dec_nr = 4'd10; end
            2'b01:   begin dec_nk = 4'd6; dec_nr = 4'd12; end
            2'b10:   begin dec_nk = 4'd8; dec_nr = 4'd14; end
            default: begin dec_nk = 4'd0; dec_nr = 4'd0; end
        endcase
        start_legal = (key_len != 2'b11) && (dec_nk <= NK_MAX4);
    end

    // The window is a shift register whose newest word sits at the top;
    // w[i-Nk] is therefore always found Nk slots below the top.
    assign load_base = IW'(NK_MAX4 - dec_nk);
    assign old_sel   = IW'(NK_MAX4 - nk);
    assign prev_word = win[NK_MAX-1];
    assign old_word  = win[old_sel];

    assign prefill    = wi < {2'b00, nk};
    assign last_word  = wi == {nr, 2'b11};
    assign phase_wrap = {1'b0, phase} == (nk - 4'd1);

    // Handshake: a round key moves on an edge with rk_valid & rk_ready; while rk_valid
    // is high rk_data/rk_idx/rk_last are frozen, and rk_valid only drops on that edge,
    // on abort, or on reset.
    assign xfer    = rk_valid && rk_ready;
    assign produce = (state == RUN) && !abort && !prod_done &&
                     !((wi[1:0] == 2'b11) && rk_valid && !rk_ready);

    assign sub_in  = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};

    always_comb begin
        new_word = old_word ^ prev_word;
        if (prefill) begin
            new_word = old_word;
        end else if (phase == 3'd0) begin
            new_word = old_word ^ sub_out ^ {rcon, 24'h000000};
        end else if ((nk == 4'd8) && (phase == 3'd4)) begin
            new_word = old_word ^ sub_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && start_legal) state_next = RUN;
            RUN: begin
                if (abort)                state_next = IDLE;
                else if (xfer && rk_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nk        <= '0;
            nr        <= '0;
            wi        <= '0;
            phase     <= '0;
            rcon      <= '0;
            prod_done <= 1'b0;
            for (int p = 0; p < NK_MAX; p++) win[p] <= '0;
            for (int b = 0; b < 3; b++) rk_buf[b] <= '0;
            rk_valid  <= 1'b0;
            rk_data   <= '0;
            rk_idx    <= '0;
            rk_last   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (start_legal) begin
                        nk        <= dec_nk;
                        nr        <= dec_nr;
                        wi        <= '0;
                        phase     <= '0;
                        rcon      <= 8'h01;
                        prod_done <= 1'b0;
                        for (int p = 0; p < NK_MAX; p++) begin
                            if (p >= int'(load_base)) win[p] <= key_word[IW'(p - int'(load_base))];
                            else                      win[p] <= '0;
                        end
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (abort) begin
                rk_valid <= 1'b0;
            end else begin
                if (xfer) begin
                    rk_valid <= 1'b0;
                    done     <= rk_last;
                end
                if (produce) begin
                    wi        <= wi + 6'd1;
                    phase     <= phase_wrap ? 3'd0 : phase + 3'd1;
                    prod_done <= last_word;
                    if (!prefill && (phase == 3'd0))
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    for (int p = 0; p < NK_MAX - 1; p++) win[p] <= win[p+1];
                    win[NK_MAX-1] <= new_word;
                    case (wi[1:0])
                        2'b00: rk_buf[0] <= new_word;
                        2'b01: rk_buf[1] <= new_word;
                        2'b10: rk_buf[2] <= new_word;
                        default: begin
                            rk_data  <= {rk_buf[0], rk_buf[1], rk_buf[2], new_word};
                            rk_idx   <= wi[5:2];
                            rk_last  <= (wi[5:2] == nr);
                            rk_valid <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

`ifdef AES_KEY_SCHED_STORE_EN
    logic [127:0] store_mem [15];
    logic [15:0]  store_vld;

    always_ff @(posedge clk) begin
        if ((state == RUN) && !abort && xfer) store_mem[rk_idx] <= rk_data;
    end

    // Valid bits keep aborted or not-yet-produced rounds reading as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_vld <= '0;
        end else if ((state == IDLE) && start && start_legal) begin
            store_vld <= '0;
        end else if ((state == RUN) && abort) begin
            store_vld <= '0;
        end else if ((state == RUN) && xfer) begin
            store_vld[rk_idx] <= 1'b1;
        end
    end

    always_comb begin
        rd_key = '0;
        if (store_vld[rd_idx]) rd_key = store_mem[rd_idx];
    end
`else
    // Stream-only build: round keys are not retained after transfer.
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: FIPS-197 expansion model, per-cycle stream/done checks, directed corner cases.
// Store checks are compiled in when AES_KEY_SCHED_STORE_EN is defined.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key = '0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b1;
    logic         rk_valid, rk_last, busy, done, err;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;

    logic         start4 = 1'b0;
    logic [1:0]   key_len4 = 2'b00;
    logic [127:0] key4 = '0;
    logic         abort4 = 1'b0;
    logic         ready4 = 1'b1;
    logic         rk_valid4, rk_last4, busy4, done4, err4;
    logic [127:0] rk_data4;
    logic [3:0]   rk_idx4;

`ifdef AES_KEY_SCHED_STORE_EN
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;
    logic [3:0]   rd_idx4 = 4'd0;
    logic [127:0] rd_key4;
`endif

    aes_key_sched #(.NK_MAX(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
        .abort(abort), .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_data(rk_data),
        .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy), .done(done),
`ifdef AES_KEY_SCHED_STORE_EN
        .rd_idx(rd_idx), .rd_key(rd_key),
`endif
        .err(err)
    );

    aes_key_sched #(.NK_MAX(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .key_len(key_len4), .key(key4),
        .abort(abort4), .rk_ready(ready4), .rk_valid(rk_valid4), .rk_data(rk_data4),
        .rk_idx(rk_idx4), .rk_last(rk_last4), .busy(busy4), .done(done4),
`ifdef AES_KEY_SCHED_STORE_EN
        .rd_idx(rd_idx4), .rd_key(rd_key4),
`endif
        .err(err4)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_xfer  = 0;
    int ready_mode = 0;

    logic [132:0] exp_q[$];
    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_t [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] model_last;
    logic [127:0] last_rk_seen = '0;

    task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] d;
        d = {v, v} << s;
        return d[15:8];
    endfunction

    // Generator walk: p steps through powers of 3, q through powers of 3^-1.
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    task automatic model_push(input logic [255:0] k, input int nk);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [127:0] rk;
        int nr;
        nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h000000};
                else if (nk > 6 && i % nk == 4) t = sub_word(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            exp_q.push_back({(r == nr), 4'(r), rk});
            model_last = rk;
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int n = 0; n < 8; n++) v[32*n +: 32] = $urandom();
        return v;
    endfunction

    // Stream checker: every transfer against the model queue, stalls hold, done follows round Nr.
    logic         exp_done = 1'b0;
    logic         stall_prev = 1'b0;
    logic [132:0] stall_val = '0;
    logic [132:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("done_pulse", 133'(done), 133'(exp_done));
            exp_done = 1'b0;
            if (stall_prev) begin
                check("stall_valid", 133'(rk_valid), 133'(1'b1));
                check("stall_hold", {rk_last, rk_idx, rk_data}, stall_val);
            end
            stall_prev = 1'b0;
            if (!abort && rk_valid) begin
                if (rk_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_xfer: got round %0d, none expected at %0t", rk_idx, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rk_data", 133'(rk_data), 133'(e[127:0]));
                        check("rk_idx_last", 133'({rk_last, rk_idx}), 133'(e[132:128]));
                        exp_done = e[132];
                        last_rk_seen = rk_data;
                        n_xfer++;
                    end
                end else begin
                    stall_prev = 1'b1;
                    stall_val  = {rk_last, rk_idx, rk_data};
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rk_ready = 1'b1;
            1:       rk_ready = 1'($urandom_range(0, 1));
            default: rk_ready = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] kl, input logic [255:0] k, input bit push, input bit with_abort);
        start   = 1'b1;
        key_len = kl;
        key     = k;
        abort   = with_abort;
        if (push) model_push(k, (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8);
        tick();
        start = 1'b0;
        abort = 1'b0;
        key   = rand256();
    endtask

    task automatic wait_done(input string name, input int exp_cyc, input bit chk_lat);
        int cyc, first_v;
        cyc = 0;
        first_v = 0;
        do begin
            tick();
            cyc++;
            if (rk_valid && first_v == 0) first_v = cyc;
        end while (!done && cyc < 400);
        if (!done) begin
            n_total++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
            exp_q.delete();
        end else begin
            if (chk_lat) begin
                check({name, "_done_latency"}, 133'(cyc), 133'(exp_cyc));
                check({name, "_first_valid"}, 133'(first_v), 133'(4));
            end
            check({name, "_drained"}, 133'(exp_q.size()), 133'(0));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, 133'(rk_valid), 133'(0));
        check({name, "_data"}, 133'(rk_data), 133'(0));
        check({name, "_idx_last"}, 133'({rk_idx, rk_last}), 133'(0));
        check({name, "_busy_done_err"}, 133'({busy, done, err}), 133'(0));
    endtask

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hffff0000ffff0000};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KFIP = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h5555aaaa5555aaaa5555aaaa5555aaaa};

    initial begin
        int g, base;
        logic [1:0] kl;
        build_sbox();
        check("model_sbox_00_53", 133'({sbox_t[8'h00], sbox_t[8'h53]}), 133'(16'h63ed));

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // FIPS-197 vectors, consumer always ready, back-to-back starts right after done.
        start_run(2'b00, K128, 1'b1, 1'b0);
        check("model_rk10_128", 133'(model_last), 133'(128'h13111d7fe3944a17f307a78b4d2b30c5));
        wait_done("aes128", 45, 1'b1);
        check("dut_rk10_128", 133'(last_rk_seen), 133'(128'h13111d7fe3944a17f307a78b4d2b30c5));

        start_run(2'b01, K192, 1'b1, 1'b0);
        check("model_rk12_192", 133'(model_last), 133'(128'ha4970a331a78dc09c418c271e3a41d5d));
        wait_done("aes192", 53, 1'b1);
        check("dut_rk12_192", 133'(last_rk_seen), 133'(128'ha4970a331a78dc09c418c271e3a41d5d));

        start_run(2'b10, K256, 1'b1, 1'b0);
        check("model_rk14_256", 133'(model_last), 133'(128'h24fc79ccbf0979e9371ac23c6d68de36));
        wait_done("aes256", 61, 1'b1);
        check("dut_rk14_256", 133'(last_rk_seen), 133'(128'h24fc79ccbf0979e9371ac23c6d68de36));
`ifdef AES_KEY_SCHED_STORE_EN
        rd_idx = 4'd0;
        #1;
        check("store_rd0", 133'(rd_key), 133'(128'h000102030405060708090a0b0c0d0e0f));
        rd_idx = 4'd14;
        #1;
        check("store_rd14", 133'(rd_key), 133'(128'h24fc79ccbf0979e9371ac23c6d68de36));
        rd_idx = 4'd15;
        #1;
        check("store_rd15", 133'(rd_key), 133'(0));
`endif

        // Randomly stalled consumer.
        ready_mode = 1;
        start_run(2'b00, KFIP, 1'b1, 1'b0);
        check("model_rk10_fips", 133'(model_last), 133'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        wait_done("fips_stall", 0, 1'b0);
        check("dut_rk10_fips", 133'(last_rk_seen), 133'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        ready_mode = 0;
        tick();

        // Rejected starts: illegal key_len, and AES-256 on a 4-word instance.
        start = 1'b1;
        key_len = 2'b11;
        start4 = 1'b1;
        key_len4 = 2'b10;
        tick();
        start = 1'b0;
        start4 = 1'b0;
        check("err_kl11", 133'({err, busy}), 133'(2'b10));
        check("err_nk_gt_max", 133'({err4, busy4}), 133'(2'b10));
        tick();
        check("err_one_cycle", 133'({err, busy, err4, busy4}), 133'(4'b0000));
        start4 = 1'b1;
        key_len4 = 2'b00;
        key4 = K128[255:128];
        tick();
        start4 = 1'b0;
        check("nk4_aes128_accept", 133'({err4, busy4}), 133'(2'b01));

        // A start while busy must be ignored.
        start_run(2'b00, K128, 1'b1, 1'b0);
        repeat (10) tick();
        start = 1'b1;
        key_len = 2'b10;
        key = rand256();
        tick();
        start = 1'b0;
        check("start_busy_no_err", 133'({err, busy}), 133'(2'b01));
        wait_done("start_while_busy", 0, 1'b0);

        // Abort in round 5 of AES-256, then restart with abort still high.
        start_run(2'b10, K256, 1'b1, 1'b0);
        base = n_xfer;
        g = 0;
        while (n_xfer < base + 5 && g < 200) begin
            tick();
            g++;
        end
        check("abort_reach_round5", 133'(n_xfer - base), 133'(5));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("abort_idle", 133'({rk_valid, busy, done}), 133'(3'b000));
`ifdef AES_KEY_SCHED_STORE_EN
        rd_idx = 4'd0;
        #1;
        check("store_after_abort", 133'(rd_key), 133'(0));
`endif
        start_run(2'b00, rand256(), 1'b1, 1'b1);
        wait_done("after_abort", 45, 1'b1);

        // Random keys and lengths, random backpressure.
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            kl = 2'($urandom_range(0, 2));
            start_run(kl, rand256(), 1'b1, 1'b0);
            wait_done("random_run", 0, 1'b0);
        end
        ready_mode = 0;
        tick();

        // Reset in the middle of an expansion.
        start_run(2'b01, rand256(), 1'b1, 1'b0);
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start_run(2'b10, rand256(), 1'b1, 1'b0);
        wait_done("post_reset", 61, 1'b1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Sequential, word-serial AES key schedule generator supporting AES-128, AES-192 and AES-256, selected at run time. It accepts a cipher key on a start strobe and streams the Nr+1 128-bit round keys, in order, over a valid/ready output handshake. It sits between the key register and the round datapath, and replaces the single-step, 256-bit-only combinational expansion stage.

## Interface
- NK_MAX, default 8: largest key length supported, in 32-bit words. Legal values are 4, 6 and 8. Sets the key port width to 32*NK_MAX.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request expansion of `key` with `key_len`.
- key_len  in  2  00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = illegal.
- key  in  32*NK_MAX  cipher key, MSB-first. w0 = key[MSB -: 32]. Words beyond Nk are ignored.
- abort  in  1  cancel expansion in progress.
- rk_ready  in  1  consumer accepts the round key.
- rk_valid  out  1  round key present on `rk_data`.
- rk_data  out  128  round key; word 4k sits in bits [127:96].
- rk_idx  out  4  round number k (0..Nr) of `rk_data`.
- rk_last  out  1  `rk_data` is round Nr.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when round Nr is accepted.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- **States**
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
  - Returns to IDLE after the round-Nr handshake or on `abort`.
- **Start**
  - Accepted only in IDLE.
  - Rejected, with an `err` pulse and no state change, if `key_len`=11 or the decoded Nk exceeds NK_MAX.
  - `start` is ignored while `busy`=1.
  - On acceptance the block latches Nk and Nr, loads the Nk key words into the Nk-word history window, clears the word counter i to 0 and sets rcon to 0x01.
- **Word production (RUN):** one word w[i] per non-stalled cycle.
  - i < Nk: w[i] is key word i.
  - i mod Nk = 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, then rcon = xtime(rcon), with 0x80 → 0x1b.
  - Nk = 8 and i mod 8 = 4: w[i] = w[i-Nk] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
  - i mod Nk is held in its own phase counter; there is no divider.
  - There is exactly one 4-byte S-box bank, shared by both SubWord cases.
- **Assembly:** words 4k, 4k+1 and 4k+2 fill a 3-word buffer. Word 4k+3 is merged with the buffer and loaded into the output register along with `rk_idx`=k.
- **Stall:** if the output register is full and not being accepted in the same cycle, production of word 4k+3 holds. Counters, window and rcon all freeze.
- **Completion:** production stops after word 4Nr+3. The round-Nr handshake pulses `done` and returns the block to IDLE.
- **Abort:** in RUN, `abort` returns to IDLE on the next edge and clears `rk_valid`. No `done` is generated. If `abort` and `start` are high together in IDLE, `start` is processed and `abort` is ignored.

## Timing
- **Reset values:** `rk_valid`, `rk_last`, `busy`, `done` and `err` are 0; `rk_data` is 0; `rk_idx` is 0; internal state is IDLE.
  - Reset mid-expansion discards everything.
- **Start to first key:** with `start` accepted at edge E0, w0..w3 are written at edges E1..E4. `rk_valid` is high after E4, giving 4 cycles of latency.
- **Throughput:** one round key per 4 cycles with `rk_ready` held at 1.
  - Total time from start to `done`: 4(Nr+1)+1 cycles, i.e. 45, 53 or 61 cycles.
- **Handshake**
  - A transfer occurs on an edge where `rk_valid` & `rk_ready`.
  - Once `rk_valid` rises, `rk_data`, `rk_idx` and `rk_last` stay stable until the transfer.
  - `rk_valid` never drops without a transfer, except on abort or reset.
- **`done` and `err`:** each is registered and high for exactly one cycle.
- **New start:** may be accepted on the cycle after `done`.

## Configuration
- Macro: `AES_KEY_SCHED_STORE_EN`.
- **Defined:**
  - Adds a 15×128 round-key store, written with each round key as it is transferred.
  - Adds ports `rd_idx` (in, 4) and `rd_key` (out, 128); `rd_key` is a combinational read of entry `rd_idx`.
  - Entries from an aborted run are invalid. Reading above Nr returns 0.
  - This allows reverse-order reads for decryption.
- **Undefined:** the store and both ports are absent, and round keys are stream-only.

## Test plan
- AES-128, key 000102…0f, `rk_ready`=1 → 11 keys, rk10 = 13111d7fe3944a17f307a78b4d2b30c5 with `rk_last`=1, `done` 45 cycles after start.
- AES-192, key 000102…17 → rk12 = a4970a331a78dc09c418c271e3a41d5d. AES-256, key 000102…1f → rk14 = 24fc79ccbf0979e9371ac23c6d68de36.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready` randomly toggled → keys unchanged while stalled, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- `key_len`=11, or `key_len`=10 with NK_MAX=4 → `err` pulse, `busy` stays 0. `start` while busy → ignored.
- `abort` during round 5 of AES-256, then a new AES-128 start → `rk_valid` drops, no `done`, second run correct. `rst_n` low mid-run → all outputs 0.
- With `AES_KEY_SCHED_STORE_EN`: after the AES-256 run, `rd_idx`=0 returns 000102…0f and `rd_idx`=14 returns rk14.
